// File: rtl/block_assembler_if.sv
// ============================================================================
// Module      : block_assembler_if
// Description : Word-in / block-out handshake bundle for block_assembler.
//               Slave modport is the assembler's view; master is the
//               upstream/controller view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface block_assembler_if;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic         wr_type;
  logic         wr_ready;
  logic         clear;
  logic         blk_take;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         blk_type;
  logic         data_received;
  logic         type_err;

  modport master (
    output wr_valid, wr_data, wr_type, clear, blk_take,
    input  wr_ready, blk_valid, blk_data, blk_type, data_received, type_err
  );

  modport slave (
    input  wr_valid, wr_data, wr_type, clear, blk_take,
    output wr_ready, blk_valid, blk_data, blk_type, data_received, type_err
  );
endinterface

`default_nettype wire

// File: rtl/block_assembler.sv
// ============================================================================
// Module      : block_assembler
// Description : Packs four 32-bit words (first word most significant) into a
//               128-bit block, queues completed blocks in a 2-entry FIFO and
//               flags mixed-type partial blocks.
//               Optional macro BLOCK_ASSEMBLER_BYTE_SWAP_EN byte-reverses each
//               incoming word before storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_assembler (
  input  wire logic         clk,
  input  wire logic         n_rst,
  block_assembler_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t         state;
  logic [1:0]     word_ct;
  logic           lat_type;
  logic [95:0]    partial;
  logic           data_received_r;
  logic           type_err_r;

  logic [127:0]   fifo_data [2];
  logic [1:0]     fifo_type;
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     fifo_count;

  logic [31:0]    word_in;
  logic           accept;
  logic           mismatch;
  logic           push;
  logic           pop;

`ifdef BLOCK_ASSEMBLER_BYTE_SWAP_EN
  assign word_in = {bus.wr_data[7:0], bus.wr_data[15:8],
                    bus.wr_data[23:16], bus.wr_data[31:24]};
`else
  assign word_in = bus.wr_data;
`endif

  // Only the final word of a block can stall; a same-cycle pop frees a slot.
  assign bus.wr_ready = (word_ct != 2'd3) || (fifo_count != 2'd2) || bus.blk_take;

  // clear overrides any write or pop presented in the same cycle.
  assign accept   = bus.wr_valid && bus.wr_ready && !bus.clear;
  assign mismatch = (state == FILL) && (bus.wr_type != lat_type);
  assign push     = accept && (word_ct == 2'd3) && !mismatch;
  assign pop      = bus.blk_take && (fifo_count != 2'd0) && !bus.clear;

  // Assembly FSM: word counter, partial block, type latch and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      word_ct         <= 2'd0;
      lat_type        <= 1'b0;
      partial         <= 96'd0;
      data_received_r <= 1'b0;
      type_err_r      <= 1'b0;
    end else if (bus.clear) begin
      state           <= IDLE;
      word_ct         <= 2'd0;
      data_received_r <= 1'b0;
      type_err_r      <= 1'b0;
    end else begin
      data_received_r <= push;
      if (accept) begin
        if (state == IDLE || mismatch) begin
          // A type change restarts assembly with this word as word 0.
          partial[95:64] <= word_in;
          lat_type       <= bus.wr_type;
          word_ct        <= 2'd1;
          state          <= FILL;
          if (mismatch) begin
            type_err_r <= 1'b1;
          end
        end else begin
          case (word_ct)
            2'd1:    partial[63:32] <= word_in;
            2'd2:    partial[31:0]  <= word_in;
            default: ;
          endcase
          word_ct <= word_ct + 2'd1;
          state   <= (word_ct == 2'd3) ? IDLE : FILL;
        end
      end
    end
  end

  // Two-entry block FIFO; slots keep their contents until rewritten.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fifo_data[0] <= 128'd0;
      fifo_data[1] <= 128'd0;
      fifo_type    <= 2'b00;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else if (bus.clear) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= {partial, word_in};
        fifo_type[wr_ptr] <= lat_type;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.blk_valid     = (fifo_count != 2'd0);
  assign bus.blk_data      = fifo_data[rd_ptr];
  assign bus.blk_type      = fifo_type[rd_ptr];
  assign bus.data_received = data_received_r;
  assign bus.type_err      = type_err_r;

endmodule

`default_nettype wire

// File: tb/tb_block_assembler.sv
// ============================================================================
// Module      : tb_block_assembler
// Description : Scoreboard bench for block_assembler. Stimulus pushes expected
//               blocks; a negedge monitor pops and compares on each blk_take.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_assembler;

  logic clk;
  logic n_rst;

  block_assembler_if bus ();

  block_assembler dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_rcv = 0;
  int rcv_ct  = 0;
  logic prev_dr = 1'b0;

  typedef struct packed {
    logic [127:0] data;
    logic         typ;
  } blk_t;
  blk_t exp_q [$];

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef BLOCK_ASSEMBLER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {sw(a), sw(b), sw(c), sw(d)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare the head block against the scoreboard on every pop.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.blk_valid && bus.blk_take) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got %h expected none", bus.blk_data);
        end else begin
          blk_t e;
          e = exp_q.pop_front();
          if (bus.blk_data !== e.data || bus.blk_type !== e.typ) begin
            bad++;
            $display("FAIL pop_block: got %h/%b expected %h/%b",
                     bus.blk_data, bus.blk_type, e.data, e.typ);
          end
        end
      end
      if (bus.data_received) begin
        rcv_ct++;
        total++;
        if (prev_dr) begin
          bad++;
          $display("FAIL dr_width: got 2-cycle pulse expected 1");
        end
      end
      prev_dr = bus.data_received;
    end else begin
      prev_dr = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic t);
    logic ok;
    ok = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_type  = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wr_timeout: got wr_ready=0 expected 1");
    end
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input logic t);
    write_word(a, t);
    write_word(b, t);
    write_word(c, t);
    write_word(d, t);
    exp_q.push_back('{data: mk(a, b, c, d), typ: t});
    exp_rcv++;
  endtask

  task automatic take(input int n);
    bus.blk_take = 1'b1;
    repeat (n) step();
    bus.blk_take = 1'b0;
  endtask

  initial begin
    n_rst        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 32'd0;
    bus.wr_type  = 1'b0;
    bus.clear    = 1'b0;
    bus.blk_take = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_blk_valid", {127'd0, bus.blk_valid}, 128'd0);
    check("rst_blk_data", bus.blk_data, 128'd0);
    check("rst_blk_type", {127'd0, bus.blk_type}, 128'd0);
    check("rst_dr", {127'd0, bus.data_received}, 128'd0);
    check("rst_type_err", {127'd0, bus.type_err}, 128'd0);
    n_rst = 1'b1;
    step();
    check("rst_wr_ready", {127'd0, bus.wr_ready}, 128'd1);

    // Basic block, latency 1
    send_block(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b1);
    check("b1_valid", {127'd0, bus.blk_valid}, 128'd1);
    check("b1_type", {127'd0, bus.blk_type}, 128'd1);
    check("b1_data", bus.blk_data,
          mk(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF));
`ifdef BLOCK_ASSEMBLER_BYTE_SWAP_EN
    check("b1_top_word", {96'd0, bus.blk_data[127:96]}, {96'd0, 32'h33221100});
`else
    check("b1_top_word", {96'd0, bus.blk_data[127:96]}, {96'd0, 32'h00112233});
`endif
    check("b1_dr_high", {127'd0, bus.data_received}, 128'd1);
    step();
    check("b1_dr_low", {127'd0, bus.data_received}, 128'd0);
    take(1);
    check("b1_empty", {127'd0, bus.blk_valid}, 128'd0);

    // Backpressure on the final word with a full FIFO
    send_block(32'h11111111, 32'h11112222, 32'h11113333, 32'h11114444, 1'b0);
    send_block(32'h22221111, 32'h22222222, 32'h22223333, 32'h22224444, 1'b1);
    write_word(32'h33331111, 1'b0);
    write_word(32'h33332222, 1'b0);
    write_word(32'h33333333, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h33334444;
    bus.wr_type  = 1'b0;
    @(negedge clk);
    check("full_stall", {127'd0, bus.wr_ready}, 128'd0);
    step();
    bus.blk_take = 1'b1;
    #1;
    check("take_unstall", {127'd0, bus.wr_ready}, 128'd1);
    step();
    bus.wr_valid = 1'b0;
    exp_q.push_back('{data: mk(32'h33331111, 32'h33332222, 32'h33333333, 32'h33334444),
                      typ: 1'b0});
    exp_rcv++;
    check("full_valid", {127'd0, bus.blk_valid}, 128'd1);
    repeat (2) step();
    bus.blk_take = 1'b0;
    check("full_drained", {127'd0, bus.blk_valid}, 128'd0);

    // Type mismatch restarts assembly
    write_word(32'h0000000A, 1'b0);
    write_word(32'h0000000B, 1'b0);
    write_word(32'h0000000C, 1'b1);
    check("terr_set", {127'd0, bus.type_err}, 128'd1);
    write_word(32'h0000000D, 1'b1);
    write_word(32'h0000000E, 1'b1);
    write_word(32'h0000000F, 1'b1);
    exp_q.push_back('{data: mk(32'h0000000C, 32'h0000000D, 32'h0000000E, 32'h0000000F),
                      typ: 1'b1});
    exp_rcv++;
    check("terr_blk_valid", {127'd0, bus.blk_valid}, 128'd1);
    check("terr_blk_type", {127'd0, bus.blk_type}, 128'd1);
    take(1);
    check("terr_sticky", {127'd0, bus.type_err}, 128'd1);

    // clear with full FIFO, partial block and a 4th word presented
    send_block(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 1'b0);
    send_block(32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004, 1'b0);
    write_word(32'hC0000001, 1'b0);
    write_word(32'hC0000002, 1'b0);
    write_word(32'hC0000003, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hC0000004;
    bus.clear    = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.clear    = 1'b0;
    exp_q.delete();
    check("clr_valid", {127'd0, bus.blk_valid}, 128'd0);
    check("clr_type_err", {127'd0, bus.type_err}, 128'd0);
    check("clr_dr", {127'd0, bus.data_received}, 128'd0);
    check("clr_wr_ready", {127'd0, bus.wr_ready}, 128'd1);
    send_block(32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004, 1'b1);
    take(1);

    // Asynchronous reset mid-block with a block queued
    send_block(32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004, 1'b1);
    write_word(32'h00000001, 1'b0);
    write_word(32'h00000002, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", {127'd0, bus.blk_valid}, 128'd0);
    check("arst_data", bus.blk_data, 128'd0);
    check("arst_type", {127'd0, bus.blk_type}, 128'd0);
    check("arst_dr", {127'd0, bus.data_received}, 128'd0);
    check("arst_type_err", {127'd0, bus.type_err}, 128'd0);
    step();
    n_rst = 1'b1;
    step();
    check("arst_wr_ready", {127'd0, bus.wr_ready}, 128'd1);
    take(1);
    check("empty_take", {127'd0, bus.blk_valid}, 128'd0);
    send_block(32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 1'b0);
    check("arst_new_data", bus.blk_data,
          mk(32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004));
    take(1);
    step();

    check("dr_count", 128'(rcv_ct), 128'(exp_rcv));
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
